// File: rtl/jt51_lin2log.sv
// Iterative linear-to-log converter: normalise by single-bit shifts, then
// interpolate a 33-entry log2 table to produce 4.8 fixed-point attenuation.
module jt51_lin2log (
  input  logic        rst_n,
  input  logic        clk,
  input  logic        clk_en,
  input  logic        start,
  input  logic [12:0] lin,
  output logic        busy,
  output logic        done,
  output logic [11:0] logatt
);

  typedef enum logic [1:0] {IDLE, NORM, LUT, CALC} state_t;

  state_t      state_q, state_d;
  logic [12:0] sh_q, sh_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  ti_q, ti_d, ti1_q, ti1_d;
  logic [2:0]  j_q, j_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [11:0] logatt_q, logatt_d;

  logic [4:0]  idx;
  logic [11:0] prod;
  logic [8:0]  frac_l;
  logic [11:0] base;

  // round(256*log2(1+k/32)), k = 0..32
  function automatic logic [8:0] tbl(input logic [5:0] k);
    case (k)
      6'd0:  tbl = 9'd0;   6'd1:  tbl = 9'd11;  6'd2:  tbl = 9'd22;
      6'd3:  tbl = 9'd33;  6'd4:  tbl = 9'd44;  6'd5:  tbl = 9'd54;
      6'd6:  tbl = 9'd63;  6'd7:  tbl = 9'd73;  6'd8:  tbl = 9'd82;
      6'd9:  tbl = 9'd92;  6'd10: tbl = 9'd100; 6'd11: tbl = 9'd109;
      6'd12: tbl = 9'd118; 6'd13: tbl = 9'd126; 6'd14: tbl = 9'd134;
      6'd15: tbl = 9'd142; 6'd16: tbl = 9'd150; 6'd17: tbl = 9'd157;
      6'd18: tbl = 9'd165; 6'd19: tbl = 9'd172; 6'd20: tbl = 9'd179;
      6'd21: tbl = 9'd186; 6'd22: tbl = 9'd193; 6'd23: tbl = 9'd200;
      6'd24: tbl = 9'd207; 6'd25: tbl = 9'd213; 6'd26: tbl = 9'd220;
      6'd27: tbl = 9'd226; 6'd28: tbl = 9'd232; 6'd29: tbl = 9'd238;
      6'd30: tbl = 9'd244; 6'd31: tbl = 9'd250;
      default: tbl = 9'd256;
    endcase
  endfunction

  // Once normalised, sh[12] is the implicit leading one: index and
  // fraction sit directly below it.
  assign idx    = sh_q[11:7];
  assign prod   = 12'(ti1_q - ti_q) * 12'(j_q);
  assign frac_l = ti_q + 9'(prod >> 3);
  assign base   = {cnt_q + 4'd1, 8'd0};

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    ti_d     = ti_q;
    ti1_d    = ti1_q;
    j_d      = j_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    logatt_d = logatt_q;
    case (state_q)
      IDLE: if (start) begin
        sh_d  = lin;
        cnt_d = 4'd0;
        if (lin == 13'd0) begin
          logatt_d = 12'hFFF;
          done_d   = 1'b1;
        end else begin
          busy_d  = 1'b1;
          state_d = NORM;
        end
      end
      NORM: begin
        if (sh_q[12]) state_d = LUT;
        else begin
          sh_d  = sh_q << 1;
          cnt_d = cnt_q + 4'd1;
        end
      end
      LUT: begin
        ti_d    = tbl({1'b0, idx});
        ti1_d   = tbl({1'b0, idx} + 6'd1);
        j_d     = sh_q[6:4];
        state_d = CALC;
      end
      CALC: begin
        logatt_d = base - {3'd0, frac_l};
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      ti_q     <= '0;
      ti1_q    <= '0;
      j_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      logatt_q <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      ti_q     <= ti_d;
      ti1_q    <= ti1_d;
      j_q      <= j_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      logatt_q <= logatt_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign logatt = logatt_q;

endmodule
